pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipe_hazard_det.sv | 29 ++
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// Holds the FSM state enum, the stage indices and the default widths.
package pipe_ctrl_pkg;

  localparam int unsigned RegAwDefault = 5;
  localparam int unsigned CntWDefault  = 16;

  localparam int unsigned NumStages = 5;
  localparam int unsigned StageIf   = 0;
  localparam int unsigned StageId   = 1;
  localparam int unsigned StageEx   = 2;
  localparam int unsigned StageMem  = 3;
  localparam int unsigned StageWb   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StDrain,
    StDone
  } pipe_state_e;

  typedef logic [NumStages-1:0] stage_vec_t;

  // Shift a new stage-occupancy bit in at IF; the oldest bit drops off past WB.
  function automatic stage_vec_t stage_shift(input stage_vec_t v, input logic fill_bit);
    return {v[NumStages-2:0], fill_bit};
  endfunction

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard detector: an EX-stage load whose destination is read by
// the instruction in ID, while both stages hold live instructions.
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = RegAwDefault
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  stage_vec_t        stage_en,
  output logic              load_use
);

  logic rs_hit;
  logic rt_hit;
  logic stages_live;

  always_comb begin
    rs_hit      = (ex_rt == id_rs);
    rt_hit      = id_uses_rt & (ex_rt == id_rt);
    stages_live = stage_en[StageId] & stage_en[StageEx];
    // Register 0 is hardwired to zero, so a load into it never creates a dependency.
    load_use    = ex_mem_read & (ex_rt != '0) & (rs_hit | rt_hit) & stages_live;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: fill/run/drain sequencing, load-use stall,
// branch flush, memory freeze and saturating stall/flush statistics.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = RegAwDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 opr_finished,
  input  logic [REG_AW-1:0]    id_rs,
  input  logic [REG_AW-1:0]    id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REG_AW-1:0]    ex_rt,
  input  logic                 ex_branch_taken,
  input  logic                 mem_busy,
  output logic [NumStages-1:0] stage_en,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 idex_bubble,
  output logic                 ifid_flush,
  output logic                 hazard,
  output logic                 done,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  pipe_state_e      state_q, state_d;
  stage_vec_t       stage_q, stage_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use_raw;
  logic live;
  logic branch;
  logic stall;
  logic in_pipe;
  logic fetching;

  pipe_hazard_det #(
    .REG_AW (REG_AW)
  ) u_hazard_det (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .stage_en    (stage_q),
    .load_use    (load_use_raw)
  );

  // Control outputs; a frozen or resetting pipe asserts no control action.
  always_comb begin
    live     = reset & ~mem_busy;
    in_pipe  = (state_q == StFill) | (state_q == StRun) | (state_q == StDrain);
    fetching = (state_q == StFill) | (state_q == StRun);

    // A taken branch discards the ID instruction, so its load-use stall is moot.
    branch = live & ex_branch_taken & stage_q[StageEx];
    stall  = live & load_use_raw & ~branch;

    hazard      = stall;
    ifid_flush  = branch;
    idex_bubble = stall | branch;
    pc_write    = live & fetching & ~stall;
    ifid_write  = live & in_pipe & ~stall;

    stage_en  = mem_busy ? '0 : stage_q;
    done      = (state_q == StDone);
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

  // Sequencing; everything holds while the memory freezes the pipe.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;

    if (!mem_busy) begin
      unique case (state_q)
        StIdle, StDone: begin
          if (valid) begin
            state_d = StFill;
            stage_d = stage_shift('0, 1'b1);
          end
        end
        StFill: begin
          stage_d = stage_shift(stage_q, 1'b1);
          if (stage_d == '1) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (opr_finished) begin
            state_d = StDrain;
            stage_d = stage_shift(stage_q, 1'b0);
          end
        end
        StDrain: begin
          if (stage_q == '0) begin
            state_d = StDone;
          end else begin
            stage_d = stage_shift(stage_q, 1'b0);
          end
        end
        default: begin
          state_d = StIdle;
          stage_d = '0;
        end
      endcase
    end
  end

  // Saturating statistics; stall and branch are already gated by the freeze.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      stage_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
